// File: rtl/serial_chain_ctrl.sv
// Serial-chain shift engine: streams tx words LSB-first onto one selected chain,
// captures the chain readback into rx words and optionally pulses its load strobe.
module serial_chain_ctrl #(
    parameter int NUM_CHAINS = 2,
    parameter int DATA_W     = 32,
    parameter int NBITS_W    = 16,
    parameter int DIV_W      = 8,
    parameter int CH_W       = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CH_W-1:0]       cfg_chain,
    input  logic [NBITS_W-1:0]    cfg_nbits,
    input  logic [DIV_W-1:0]      cfg_half,
    input  logic                  cfg_load_en,
    input  logic [DATA_W-1:0]     tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_W-1:0]     rx_data,
    output logic                  rx_valid,
    output logic                  rx_last,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_CHAINS-1:0] sclk,
    output logic [NUM_CHAINS-1:0] sdo,
    output logic [NUM_CHAINS-1:0] sload,
    input  logic [NUM_CHAINS-1:0] sdi
);

    localparam int POS_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [POS_W-1:0]   POS_LAST = POS_W'(DATA_W - 1);
    localparam logic [POS_W-1:0]   POS_ONE  = POS_W'(1);
    localparam logic [NBITS_W-1:0] LEFT_ONE = NBITS_W'(1);
    localparam logic [DIV_W:0]     CNT_ONE  = (DIV_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LOW     = 3'd2,
        HIGH    = 3'd3,
        WAIT_RX = 3'd4,
        LOAD    = 3'd5,
        FINISH  = 3'd6
    } state_t;

    state_t                  state_r, state_nxt_s, adv_state_s;
    logic [CH_W-1:0]         chain_r, chain_nxt_s;
    logic [DIV_W-1:0]        half_r, half_nxt_s;
    logic                    load_en_r, load_en_nxt_s;
    logic [NBITS_W-1:0]      left_r, left_nxt_s;
    logic [POS_W-1:0]        pos_r, pos_nxt_s, adv_pos_s;
    logic [DIV_W:0]          cnt_r, cnt_nxt_s, half_end_s, load_end_s;
    logic [DATA_W-1:0]       word_r, word_nxt_s, acc_r, acc_nxt_s;
    logic [DATA_W-1:0]       rx_data_r, rx_data_nxt_s;
    logic                    rx_valid_r, rx_valid_nxt_s, rx_last_r, rx_last_nxt_s;
    logic                    busy_r, busy_nxt_s, done_r, done_nxt_s;
    logic [NUM_CHAINS-1:0]   sclk_r, sclk_nxt_s, sdo_r, sdo_nxt_s, sload_r, sload_nxt_s;
    logic                    last_bit_s, word_end_s, need_xfer_s, rx_free_s;
    logic                    do_adv_s, xfer_s, data_phase_s;

    // Bit-completion bookkeeping shared by the HIGH exit and WAIT_RX
    always_comb begin
        last_bit_s  = (left_r == LEFT_ONE);
        word_end_s  = (pos_r == POS_LAST);
        need_xfer_s = last_bit_s || word_end_s;
        rx_free_s   = !rx_valid_r || rx_ready;
        half_end_s  = {1'b0, half_r};
        load_end_s  = {half_r, 1'b1};
        if (last_bit_s) begin
            adv_state_s = load_en_r ? LOAD : FINISH;
            adv_pos_s   = '0;
        end else if (word_end_s) begin
            adv_state_s = FETCH;
            adv_pos_s   = '0;
        end else begin
            adv_state_s = LOW;
            adv_pos_s   = pos_r + POS_ONE;
        end
    end

    // Next-state and datapath logic; abort overrides everything including start
    always_comb begin
        state_nxt_s   = state_r;
        chain_nxt_s   = chain_r;
        half_nxt_s    = half_r;
        load_en_nxt_s = load_en_r;
        left_nxt_s    = left_r;
        pos_nxt_s     = pos_r;
        cnt_nxt_s     = cnt_r;
        word_nxt_s    = word_r;
        acc_nxt_s     = acc_r;
        do_adv_s      = 1'b0;
        if (abort) begin
            state_nxt_s = IDLE;
            left_nxt_s  = '0;
            pos_nxt_s   = '0;
            cnt_nxt_s   = '0;
            acc_nxt_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        chain_nxt_s   = cfg_chain;
                        half_nxt_s    = cfg_half;
                        load_en_nxt_s = cfg_load_en;
                        left_nxt_s    = cfg_nbits;
                        pos_nxt_s     = '0;
                        cnt_nxt_s     = '0;
                        acc_nxt_s     = '0;
                        if (cfg_nbits != '0) state_nxt_s = FETCH;
                        else if (cfg_load_en) state_nxt_s = LOAD;
                        else state_nxt_s = FINISH;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                FETCH: begin
                    if (tx_valid) begin
                        word_nxt_s  = tx_data;
                        cnt_nxt_s   = '0;
                        state_nxt_s = LOW;
                    end else begin
                        state_nxt_s = FETCH;
                    end
                end
                LOW: begin
                    if (cnt_r == half_end_s) begin
                        acc_nxt_s[pos_r] = sdi[chain_r];
                        cnt_nxt_s        = '0;
                        state_nxt_s      = HIGH;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (cnt_r != half_end_s) begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end else if (need_xfer_s && !rx_free_s) begin
                        state_nxt_s = WAIT_RX;
                    end else begin
                        state_nxt_s = adv_state_s;
                        pos_nxt_s   = adv_pos_s;
                        left_nxt_s  = left_r - LEFT_ONE;
                        cnt_nxt_s   = '0;
                        acc_nxt_s   = need_xfer_s ? '0 : acc_r;
                        do_adv_s    = 1'b1;
                    end
                end
                WAIT_RX: begin
                    if (rx_free_s) begin
                        state_nxt_s = adv_state_s;
                        pos_nxt_s   = adv_pos_s;
                        left_nxt_s  = left_r - LEFT_ONE;
                        cnt_nxt_s   = '0;
                        acc_nxt_s   = '0;
                        do_adv_s    = 1'b1;
                    end else begin
                        state_nxt_s = WAIT_RX;
                    end
                end
                LOAD: begin
                    if (cnt_r == load_end_s) begin
                        cnt_nxt_s   = '0;
                        state_nxt_s = FINISH;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                FINISH:  state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // rx holding register: a transfer may land in the same cycle as a handshake
    always_comb begin
        xfer_s        = do_adv_s && need_xfer_s;
        rx_data_nxt_s = rx_data_r;
        rx_last_nxt_s = rx_last_r;
        if (xfer_s) begin
            rx_valid_nxt_s = 1'b1;
            rx_data_nxt_s  = acc_r;
            rx_last_nxt_s  = last_bit_s;
        end else if (rx_valid_r && rx_ready) begin
            rx_valid_nxt_s = 1'b0;
        end else begin
            rx_valid_nxt_s = rx_valid_r;
        end
    end

    // Pin and status values for the state being entered; other chains stay quiet
    always_comb begin
        data_phase_s = (state_nxt_s == LOW) || (state_nxt_s == HIGH) || (state_nxt_s == WAIT_RX);
        sclk_nxt_s   = '0;
        sdo_nxt_s    = '0;
        sload_nxt_s  = '0;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            sclk_nxt_s[i]  = (chain_nxt_s == CH_W'(i)) && (state_nxt_s == HIGH);
            sdo_nxt_s[i]   = (chain_nxt_s == CH_W'(i)) && data_phase_s && word_nxt_s[pos_nxt_s];
            sload_nxt_s[i] = (chain_nxt_s == CH_W'(i)) && (state_nxt_s == LOAD);
        end
        busy_nxt_s = (state_nxt_s != IDLE);
        done_nxt_s = (state_nxt_s == FINISH);
    end

    // State and output registers
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_r    <= IDLE;
            chain_r    <= '0;
            half_r     <= '0;
            load_en_r  <= 1'b0;
            left_r     <= '0;
            pos_r      <= '0;
            cnt_r      <= '0;
            word_r     <= '0;
            acc_r      <= '0;
            rx_data_r  <= '0;
            rx_valid_r <= 1'b0;
            rx_last_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            sclk_r     <= '0;
            sdo_r      <= '0;
            sload_r    <= '0;
        end else begin
            state_r    <= state_nxt_s;
            chain_r    <= chain_nxt_s;
            half_r     <= half_nxt_s;
            load_en_r  <= load_en_nxt_s;
            left_r     <= left_nxt_s;
            pos_r      <= pos_nxt_s;
            cnt_r      <= cnt_nxt_s;
            word_r     <= word_nxt_s;
            acc_r      <= acc_nxt_s;
            rx_data_r  <= rx_data_nxt_s;
            rx_valid_r <= rx_valid_nxt_s;
            rx_last_r  <= rx_last_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            sclk_r     <= sclk_nxt_s;
            sdo_r      <= sdo_nxt_s;
            sload_r    <= sload_nxt_s;
        end
    end

    // tx_ready is the consume strobe of the valid/ready pair, so it follows tx_valid directly
    assign tx_ready = (state_r == FETCH) && tx_valid;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign rx_last  = rx_last_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign sclk     = sclk_r;
    assign sdo      = sdo_r;
    assign sload    = sload_r;

endmodule

// File: tb/tb_serial_chain_ctrl.sv
// Scoreboard bench for serial_chain_ctrl with every chain looped back (sdi = sdo).
module tb_serial_chain_ctrl;

    localparam int NUM_CHAINS = 2;
    localparam int DATA_W     = 32;
    localparam int NBITS_W    = 16;
    localparam int DIV_W      = 8;
    localparam int CH_W       = 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start, abort, cfg_load_en;
    logic [CH_W-1:0]       cfg_chain;
    logic [NBITS_W-1:0]    cfg_nbits;
    logic [DIV_W-1:0]      cfg_half;
    logic [DATA_W-1:0]     tx_data, rx_data;
    logic                  tx_valid, tx_ready, rx_valid, rx_last, rx_ready, busy, done;
    logic [NUM_CHAINS-1:0] sclk, sdo, sload, sdi;

    always #5 clk = ~clk;
    assign sdi = sdo;

    serial_chain_ctrl #(
        .NUM_CHAINS(NUM_CHAINS), .DATA_W(DATA_W), .NBITS_W(NBITS_W), .DIV_W(DIV_W), .CH_W(CH_W)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .abort(abort),
        .cfg_chain(cfg_chain), .cfg_nbits(cfg_nbits), .cfg_half(cfg_half), .cfg_load_en(cfg_load_en),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
        .busy(busy), .done(done), .sclk(sclk), .sdo(sdo), .sload(sload), .sdi(sdi)
    );

    int tests_run = 0;
    int tests_failed = 0;
    logic [32:0] exp_q[$];
    logic [31:0] txq[$];
    int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0;
    int rise_cnt, other_act, load_cyc, load_bad, tx_pulses, mon_ch;
    logic [63:0] obs_bits;
    bit sclk_prev, tx_fire;
    logic [NUM_CHAINS-1:0] other_m;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Observation of pins, strobes and the rx scoreboard, away from the active edge
    always @(negedge clk) begin
        logic [32:0] e;
        if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) check_val("rx_unexpected", 64'(exp_q.size()), 64'd1);
            else begin
                e = exp_q.pop_front();
                check_val("rx_word", {31'd0, rx_last, rx_data}, {31'd0, e});
            end
        end
        if (sclk[mon_ch] && !sclk_prev) begin
            if (rise_cnt < 64) obs_bits[rise_cnt] = sdo[mon_ch];
            rise_cnt++;
        end
        sclk_prev = sclk[mon_ch];
        if (|((sclk | sdo | sload) & other_m)) other_act++;
        if (sload[mon_ch]) begin
            load_cyc++;
            if (sclk[mon_ch] || sdo[mon_ch]) load_bad++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (tx_valid && tx_ready) begin
            tx_pulses++;
            tx_fire = 1'b1;
        end
    end

    // tx word source fed from txq
    initial begin
        tx_valid = 1'b0;
        tx_data  = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (tx_fire) begin
                if (txq.size() > 0) void'(txq.pop_front());
                tx_fire = 1'b0;
            end
            tx_valid = (txq.size() > 0);
            if (tx_valid) tx_data = txq[0];
            else tx_data = 32'd0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon(input int ch);
        mon_ch = ch; rise_cnt = 0; other_act = 0; load_cyc = 0; load_bad = 0;
        tx_pulses = 0; obs_bits = 64'd0; sclk_prev = 1'b0;
        other_m = ~(NUM_CHAINS'(1) << ch);
    endtask

    task automatic start_op(input int ch, input int nb, input int hf, input bit le);
        @(posedge clk); #1;
        cfg_chain = CH_W'(ch); cfg_nbits = NBITS_W'(nb); cfg_half = DIV_W'(hf);
        cfg_load_en = le; start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; cfg_chain = ~cfg_chain; cfg_nbits = 16'hFFFF; cfg_half = 8'h7F; cfg_load_en = ~le;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check_val(tag, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        bit seen;
        int d0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; rx_ready = 1'b1;
        cfg_chain = 1'b0; cfg_nbits = 16'd0; cfg_half = 8'd0; cfg_load_en = 1'b0;
        clear_mon(0);
        repeat (3) @(posedge clk); #1;
        check_val("rst_pins", {58'd0, sclk, sdo, sload}, 64'd0);
        check_val("rst_status", {59'd0, busy, done, rx_valid, rx_last, tx_ready}, 64'd0);
        check_val("rst_rx_data", {32'd0, rx_data}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Loopback, chain 0, 8 bits, H=2
        clear_mon(0);
        txq.push_back(32'hA5); exp_q.push_back({1'b1, 32'h0000_00A5});
        start_op(0, 8, 1, 1'b0);
        wait_done(200, "t1_done");
        check_val("t1_cycles", 64'(done_cyc - start_cyc + 1), 64'd35);
        check_val("t1_sclk_pulses", 64'(rise_cnt), 64'd8);
        check_val("t1_sdo_bits", {56'd0, obs_bits[7:0]}, 64'hA5);
        check_val("t1_other_chain", 64'(other_act), 64'd0);
        check_val("t1_tx_ready", 64'(tx_pulses), 64'd1);
        check_val("t1_busy_after", 64'(busy), 64'd0);

        // Multi-word on chain 1 with rx backpressure, H=1
        clear_mon(1);
        rx_ready = 1'b0;
        txq.push_back(32'h1234_5678); txq.push_back(32'h0000_009A);
        exp_q.push_back({1'b0, 32'h1234_5678}); exp_q.push_back({1'b1, 32'h0000_009A});
        start_op(1, 40, 0, 1'b0);
        for (int i = 0; i < 300 && !rx_valid; i++) @(negedge clk);
        check_val("t2_first_rx", 64'(rx_valid), 64'd1);
        d0 = done_cnt;
        repeat (50) @(posedge clk); #1;
        check_val("t2_stall_pins", {62'd0, sclk[1], sdo[1]}, 64'd1);
        check_val("t2_stall_busy", 64'(busy), 64'd1);
        check_val("t2_stall_bits", 64'(rise_cnt), 64'd40);
        check_val("t2_stall_nodone", 64'(done_cnt - d0), 64'd0);
        rx_ready = 1'b1;
        wait_done(200, "t2_done");
        check_val("t2_sdo_bits", {24'd0, obs_bits[39:0]}, 64'h9A_1234_5678);
        check_val("t2_other_chain", 64'(other_act), 64'd0);
        check_val("t2_tx_ready", 64'(tx_pulses), 64'd2);

        // Load strobe after 4 bits, H=4
        clear_mon(0);
        txq.push_back(32'hB); exp_q.push_back({1'b1, 32'h0000_000B});
        start_op(0, 4, 3, 1'b1);
        wait_done(300, "t3_done");
        check_val("t3_cycles", 64'(done_cyc - start_cyc + 1), 64'd43);
        check_val("t3_sload_len", 64'(load_cyc), 64'd8);
        check_val("t3_sload_quiet", 64'(load_bad), 64'd0);
        check_val("t3_sdo_bits", {60'd0, obs_bits[3:0]}, 64'hB);

        // Zero-length with load (tx word offered but never consumed), then without
        clear_mon(0);
        txq.push_back(32'hDEAD_BEEF);
        start_op(0, 0, 2, 1'b1);
        wait_done(100, "t4_done");
        check_val("t4_cycles", 64'(done_cyc - start_cyc + 1), 64'd8);
        check_val("t4_sload_len", 64'(load_cyc), 64'd6);
        check_val("t4_no_sclk", 64'(rise_cnt), 64'd0);
        check_val("t4_no_tx_ready", 64'(tx_pulses), 64'd0);
        @(posedge clk); #1;
        txq.delete();
        repeat (2) @(posedge clk);
        clear_mon(1);
        start_op(1, 0, 5, 1'b0);
        wait_done(100, "t4b_done");
        check_val("t4b_cycles", 64'(done_cyc - start_cyc + 1), 64'd2);
        check_val("t4b_no_sload", 64'(load_cyc), 64'd0);

        // Abort mid-shift, abort beating start, then a normal run
        clear_mon(0);
        txq.push_back(32'h0000_BEEF);
        start_op(0, 16, 1, 1'b0);
        for (int i = 0; i < 200 && rise_cnt < 5; i++) @(posedge clk);
        check_val("t5_reached_bit5", 64'(rise_cnt), 64'd5);
        #1 abort = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #1 abort = 1'b0;
        check_val("t5_abort_pins", {58'd0, sclk, sdo, sload}, 64'd0);
        check_val("t5_abort_busy", 64'(busy), 64'd0);
        repeat (20) @(posedge clk); #1;
        check_val("t5_no_done", 64'(done_cnt - d0), 64'd0);
        check_val("t5_no_rx", 64'(rx_valid), 64'd0);
        start = 1'b1; abort = 1'b1; cfg_nbits = 16'd8; cfg_chain = 1'b0;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        check_val("t5_abort_over_start", 64'(busy), 64'd0);
        clear_mon(0);
        txq.push_back(32'h3C); exp_q.push_back({1'b1, 32'h0000_003C});
        start_op(0, 8, 0, 1'b0);
        wait_done(100, "t5_rerun_done");
        check_val("t5_rerun_cycles", 64'(done_cyc - start_cyc + 1), 64'd19);
        check_val("t5_rerun_bits", {56'd0, obs_bits[7:0]}, 64'h3C);

        // Async reset in a HIGH phase with an rx word pending
        rx_ready = 1'b0;
        clear_mon(0);
        txq.push_back(32'h5);
        start_op(0, 4, 0, 1'b0);
        wait_done(100, "t6_first_done");
        check_val("t6_pending_rx", {31'd0, rx_valid, rx_data}, {31'd0, 1'b1, 32'h5});
        txq.push_back(32'hFF);
        start_op(0, 8, 2, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (sclk[0]) seen = 1'b1;
        end
        check_val("t6_high_seen", 64'(seen), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_rst_pins", {58'd0, sclk, sdo, sload}, 64'd0);
        check_val("t6_rst_status", {62'd0, busy, rx_valid}, 64'd0);
        check_val("t6_rst_rx_data", {32'd0, rx_data}, 64'd0);
        @(posedge clk); #1;
        txq.delete();
        rst_n = 1'b1; rx_ready = 1'b1;
        repeat (3) @(posedge clk);

        check_val("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_chain_ctrl.md
Name: serial_chain_ctrl

Overview:
- Parametrised serial-chain engine for the CMS pixel test firmware. It replaces the fixed config/scan shifting with one engine that can drive NUM_CHAINS independent DUT chains (config_in/config_clk/config_load, scan_in/scan_load, ...).
- Shifts a programmable number of bits out of a word stream, captures the chain readback into a word stream, and optionally pulses the chain's load strobe.
- Sits between the AXI-lite register/FIFO layer and the DUT pins, in the S_AXI_ACLK domain.

Parameters:
- NUM_CHAINS, 2: number of independent serial chains.
- DATA_W, 32: width of the tx/rx word streams.
- NBITS_W, 16: width of the bit-count field; max chain length is 2^NBITS_W-1.
- DIV_W, 8: width of the half-period divider field.
- CH_W, max(1,$clog2(NUM_CHAINS)): width of the chain-select field.

Ports:
- S_AXI_ACLK  in  1  single clock for all logic.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; ignored while busy.
- abort  in  1  terminates any operation.
- cfg_chain  in  CH_W  chain index, latched at start.
- cfg_nbits  in  NBITS_W  bits to shift, latched at start.
- cfg_half  in  DIV_W  sclk half-period is H=cfg_half+1 ACLK cycles, latched at start.
- cfg_load_en  in  1  pulse sload after the shift, latched at start.
- tx_data  in  DATA_W  outgoing word, LSB shifted first.
- tx_valid  in  1  tx word available.
- tx_ready  out  1  tx word consumed this cycle.
- rx_data  out  DATA_W  captured word, first-captured bit at LSB.
- rx_valid  out  1  rx word held.
- rx_last  out  1  rx word is the final (possibly partial) word.
- rx_ready  in  1  downstream accepts rx word.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse on normal completion.
- sclk  out  NUM_CHAINS  chain shift clocks.
- sdo  out  NUM_CHAINS  chain serial data out.
- sload  out  NUM_CHAINS  chain load strobes.
- sdi  in  NUM_CHAINS  chain serial data in; already registered by the integrator.

Behaviour:
- Reset, asynchronous: all outputs 0, FSM in IDLE, counters 0, rx_data 0.
- Unselected chains: sclk/sdo/sload held 0 at all times. Only the latched chain toggles.
- FSM states: IDLE, FETCH, LOW, HIGH, WAIT_RX, LOAD, FINISH.
- IDLE -> start: latch cfg_*, busy=1. Go to FETCH if nbits>0; else LOAD if load_en; else FINISH.
- FETCH: wait for tx_valid. On tx_valid, tx_ready=1 for exactly 1 cycle, word latched, go to LOW.
- LOW:
  - sclk=0, sdo=current bit, held for H cycles.
  - In the last LOW cycle, sdi[chain] is sampled into accumulator bit (bit_idx mod DATA_W).
  - Then go to HIGH.
- HIGH: sclk=1 for H cycles. On exit:
  - If accumulator holds DATA_W bits, or the bit is the last one: transfer to rx (zero-padding unused MSBs; rx_last=1 if last). If rx_valid is still set, go to WAIT_RX instead and transfer when freed.
  - Next state: LOAD/FINISH if last bit; FETCH if the next bit starts a new word; else LOW.
- WAIT_RX: sclk=0, sdo held; transfer when rx_valid=0, then continue as from HIGH exit.
- rx handshake: rx_valid drops the cycle after rx_valid&rx_ready. A transfer may occur in that same handshake cycle (no bubble required).
- LOAD: sdo=0, sclk=0, sload=1 for 2H cycles, then FINISH.
- FINISH: done=1 for one cycle, busy=0 next cycle, return to IDLE. The final rx word may still be pending; busy does not wait for it.
- Timing: per bit 2H cycles plus FETCH/WAIT_RX stall. Total (no stalls, tx_valid held) = 2H·nbits + ceil(nbits/DATA_W) fetch cycles + (load_en?2H:0) + 2.
- abort, any state: next cycle sclk/sdo/sload=0, busy=0, state IDLE, no done pulse. Accumulator is discarded; a pending rx word stays valid until accepted. abort has priority over a simultaneous start.
- start while busy: ignored. cfg_* changes after start have no effect.
- cfg_half=0: H=1, so sclk = ACLK/2.
- Counters sized by NBITS_W; no wrap occurs because the max count is 2^NBITS_W-1.

Test Plan:
- Loopback: sdo[0]->sdi[0], chain 0, nbits=8, half=1, load_en=0, tx=0xA5 -> 8 sclk pulses (H=2), sdo LSB-first 1,0,1,0,0,1,0,1; rx_data=0x000000A5, rx_last=1, done after 35 cycles; chain 1 pins stay 0.
- Multi-word with backpressure: chain 1 loopback, nbits=40, tx=0x12345678 then 0x9A, rx_ready=0 for 50 cycles after the first rx_valid -> engine waits in WAIT_RX with sclk=0 after bit 40. rx words are 0x12345678 then 0x0000009A (rx_last=1). No bits lost.
- Load strobe: nbits=4, half=3, load_en=1 -> after 4 bits sload[ch]=1 for exactly 8 cycles with sclk=0, sdo=0; then done pulse.
- Zero-length: nbits=0, load_en=1 -> no tx_ready, no sclk edge, sload for 2H cycles, done. With load_en=0: done 2 cycles after start.
- Abort mid-shift: abort at bit 5 of 16 -> all pins 0 next cycle, busy=0, no done. A following start runs normally.
- Async reset during HIGH phase: S_AXI_ARESETN low mid-cycle -> sclk/sdo/sload/busy/rx_valid drop to 0 immediately, without waiting for a clock edge.
